// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out register reader.
package reg_serializer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_serializer_if.sv
// Handshake and status bundle between a word controller and reg_serializer.
interface reg_serializer_if #(
  parameter int WIDTH = 16
);
  logic                           start;
  logic [WIDTH-1:0]               d_in;
  logic                           ser_ready;
  logic                           ser_out;
  logic                           ser_valid;
  logic                           busy;
  logic                           done;
  logic [$clog2(WIDTH+1)-1:0]     bit_cnt;

  // Controller / consumer side
  modport master (
    output start, d_in, ser_ready,
    input  ser_out, ser_valid, busy, done, bit_cnt
  );

  // Serializer side
  modport slave (
    input  start, d_in, ser_ready,
    output ser_out, ser_valid, busy, done, bit_cnt
  );
endinterface

// File: rtl/reg_serializer_shift_reg_piso.sv
// Parallel-load, serial-out shift register. Shifts toward the output end
// and fills with zeros, so it drains to all-zero after WIDTH shifts.
module shift_reg_piso #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next-state: load wins over shift; otherwise hold
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = d_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  // Shift register state, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The output end is a flop bit, so ser_o is registered
  assign ser_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/reg_serializer.sv
// Captures a word on start and emits it one bit per valid/ready transfer,
// reporting busy while active and a one-cycle done after the last bit.
module reg_serializer
  import reg_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_serializer_if.slave   bus
);

  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load;
  logic               shift;
  logic               xfer;

  // A bit is consumed only on an edge where both sides agree
  assign xfer = valid_q & bus.ser_ready;

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (bus.start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // start is deliberately not looked at here
        if (xfer) begin
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .d_i     (bus.d_in),
    .ser_o   (bus.ser_out)
  );

  assign bus.ser_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: an MSB-first and an LSB-first instance share
// one stimulus stream; each is checked against a word-level expectation.
module tb_reg_serializer;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  d_in;
  logic          ser_ready;

  int tests = 0;
  int fails = 0;

  reg_serializer_if #(.WIDTH(W)) if_m ();
  reg_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.start     = start;
  assign if_m.d_in      = d_in;
  assign if_m.ser_ready = ser_ready;
  assign if_l.start     = start;
  assign if_l.d_in      = d_in;
  assign if_l.ser_ready = ser_ready;

  reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m)
  );

  reg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against one expectation
  task automatic chk_all(input string tag, input logic vld, input logic bm, input logic bl,
                         input logic bsy, input logic dn, input int cnt);
    chk({tag, ":vld_m"},  32'(if_m.ser_valid), 32'(vld));
    chk({tag, ":out_m"},  32'(if_m.ser_out),   32'(bm));
    chk({tag, ":busy_m"}, 32'(if_m.busy),      32'(bsy));
    chk({tag, ":done_m"}, 32'(if_m.done),      32'(dn));
    chk({tag, ":cnt_m"},  32'(if_m.bit_cnt),   32'(cnt));
    chk({tag, ":vld_l"},  32'(if_l.ser_valid), 32'(vld));
    chk({tag, ":out_l"},  32'(if_l.ser_out),   32'(bl));
    chk({tag, ":busy_l"}, 32'(if_l.busy),      32'(bsy));
    chk({tag, ":done_l"}, 32'(if_l.done),      32'(dn));
    chk({tag, ":cnt_l"},  32'(if_l.bit_cnt),   32'(cnt));
  endtask

  // One word: called at a negedge with both DUTs idle. Returns at a negedge
  // with both idle again, so consecutive calls are back-to-back.
  // mode 0: ready high; 1: random ready and random start noise;
  // 2: three-cycle stall once 5 bits are accepted.
  // ign: pulse start with 16'hFFFF when 3 bits are accepted.
  // abort_at >= 0: reset once that many bits are accepted.
  task automatic xfer(input logic [W-1:0] w, input int mode, input int abort_at, input bit ign);
    int k;
    int cyc;
    int stall;
    k     = 0;
    cyc   = 0;
    stall = 0;
    start = 1'b1;
    d_in  = w;
    ser_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    d_in  = W'($urandom);
    while (k < W && cyc < 400) begin
      chk_all("shift", 1'b1, w[W-1-k], w[k], 1'b1, 1'b0, k);
      if (k == abort_at) begin
        rst_n = 1'b0;
        ser_ready = 1'b1;
        @(negedge clk);
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        ser_ready = 1'b0;
        @(negedge clk);
        chk_all("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        return;
      end
      start = 1'b0;
      d_in  = W'($urandom);
      case (mode)
        1:       begin ser_ready = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1)); end
        2:       begin
                   ser_ready = !(k == 5 && stall < 3);
                   if (!ser_ready) stall++;
                 end
        default: ser_ready = 1'b1;
      endcase
      if (ign && k == 3) begin
        start = 1'b1;
        d_in  = 16'hFFFF;
      end
      @(negedge clk);
      if (ser_ready) k++;
      cyc++;
    end
    chk("bits_accepted", 32'(k), 32'(W));
    if (mode == 2) chk("stall_cycles", 32'(stall), 32'd3);
    chk_all("done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, W);
    // start during DONE must be dropped
    start = 1'b1;
    d_in  = W'($urandom);
    ser_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b1;
    d_in      = 16'hFFFF;
    ser_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    xfer(16'h04D2, 0, -1, 1'b0);
    xfer(16'h04D2, 2, -1, 1'b0);
    xfer(16'h04D2, 0, -1, 1'b1);
    xfer(16'h8001, 0, -1, 1'b0);
    xfer(16'h00FF, 0, -1, 1'b0);
    xfer(W'($urandom), 0, 7, 1'b0);
    xfer(16'hA5A5, 0, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      xfer(W'($urandom), 1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
